// File: rtl/vend_controller.sv
// Vending sequencer: select/compare/vend, greedy change payout, then coin-counter clear.
// Optional idle-refund timer is built when VEND_CONTROLLER_TIMEOUT_EN is defined.
module vend_controller #(
  parameter logic [9:0]  PRICE0         = 10'd50,
  parameter logic [9:0]  PRICE1         = 10'd75,
  parameter logic [9:0]  PRICE2         = 10'd100,
  parameter logic [9:0]  PRICE3         = 10'd125,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] money_count,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  output logic       coin_lock,
  output logic       counter_clr,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       denied,
  output logic       ret_q,
  output logic       ret_d,
  output logic       ret_n,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VEND   = 2'd1;
  localparam logic [1:0] ST_CHANGE = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  function automatic logic [9:0] price_of(input logic [1:0] item);
    case (item)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      2'd3:    price_of = PRICE3;
      default: price_of = PRICE0;
    endcase
  endfunction

  // Largest coin not exceeding the amount still owed; 0 once below a nickel.
  function automatic logic [9:0] coin_value(input logic [9:0] due);
    if (due >= 10'd25) begin
      coin_value = 10'd25;
    end else if (due >= 10'd10) begin
      coin_value = 10'd10;
    end else if (due >= 10'd5) begin
      coin_value = 10'd5;
    end else begin
      coin_value = 10'd0;
    end
  endfunction

  logic [1:0] state_q, state_d;
  logic [9:0] change_due_q, change_due_d;
  logic [1:0] vend_item_q, vend_item_d;
  logic [9:0] price_s;
  logic [9:0] coin_s;
  logic [9:0] coin_next_s;
  logic       refund_s;
  logic       timeout_s;
  logic       denied_d;

  logic lock_q, clr_q, vend_q, denied_q, rq_q, rd_q, rn_q, busy_q;

`ifdef VEND_CONTROLLER_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic [9:0]  money_prev_q;
  logic        count_en_s;

  // Idle timer: counts only while credit is held unchanged and nobody touches the panel.
  always_comb begin
    count_en_s = (state_q == ST_IDLE) && (money_count != 10'd0) &&
                 (money_count == money_prev_q) && !sel_valid;
    if (count_en_s) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = 16'd0;
    end
    timeout_s = count_en_s && (timer_d >= TIMEOUT_CYCLES);
  end

  // Timer and credit-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= 16'd0;
      money_prev_q <= 10'd0;
    end else begin
      timer_q      <= timer_d;
      money_prev_q <= money_count;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign timeout_s        = 1'b0;
`endif

  // Next-state and change-due computation.
  always_comb begin
    state_d      = state_q;
    change_due_d = change_due_q;
    vend_item_d  = vend_item_q;
    denied_d     = 1'b0;
    coin_s       = 10'd0;
    price_s      = price_of(sel_item);
    refund_s     = (cancel || timeout_s) && (money_count != 10'd0);
    case (state_q)
      ST_IDLE: begin
        if (refund_s) begin
          change_due_d = money_count;
          state_d      = (money_count >= 10'd5) ? ST_CHANGE : ST_CLEAR;
        end else if (sel_valid) begin
          vend_item_d = sel_item;
          if (money_count >= price_s) begin
            change_due_d = money_count - price_s;
            state_d      = ST_VEND;
          end else begin
            denied_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        state_d = (change_due_q >= 10'd5) ? ST_CHANGE : ST_CLEAR;
      end
      ST_CHANGE: begin
        coin_s       = coin_value(change_due_q);
        change_due_d = change_due_q - coin_s;
        state_d      = (change_due_d >= 10'd5) ? ST_CHANGE : ST_CLEAR;
      end
      ST_CLEAR: begin
        change_due_d = 10'd0;
        state_d      = ST_IDLE;
      end
      default: begin
        change_due_d = 10'd0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state cycle.
  assign coin_next_s = (state_d == ST_CHANGE) ? coin_value(change_due_d) : 10'd0;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      change_due_q <= 10'd0;
      vend_item_q  <= 2'd0;
      lock_q       <= 1'b0;
      clr_q        <= 1'b0;
      vend_q       <= 1'b0;
      denied_q     <= 1'b0;
      rq_q         <= 1'b0;
      rd_q         <= 1'b0;
      rn_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      change_due_q <= change_due_d;
      vend_item_q  <= vend_item_d;
      lock_q       <= (state_d != ST_IDLE);
      clr_q        <= (state_d == ST_CLEAR);
      vend_q       <= (state_d == ST_VEND);
      denied_q     <= denied_d;
      rq_q         <= (coin_next_s == 10'd25);
      rd_q         <= (coin_next_s == 10'd10);
      rn_q         <= (coin_next_s == 10'd5);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign coin_lock   = lock_q;
  assign counter_clr = clr_q;
  assign vend        = vend_q;
  assign vend_item   = vend_item_q;
  assign denied      = denied_q;
  assign ret_q       = rq_q;
  assign ret_d       = rd_q;
  assign ret_n       = rn_q;
  assign busy        = busy_q;

endmodule
